// File: rtl/register_file_ctl.sv
// Parametrised register file with PC auto-increment, SP push/pop adjust and a sticky stack fault.
// Two combinational read ports with optional same-cycle write forwarding.
module register_file_ctl #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 13,
  parameter int ADDR_W   = 4,
  parameter int PC_ID    = 12,
  parameter int SP_ID    = 10,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter logic [WIDTH-1:0] SP_RESET = '1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] read1_id,
  output logic [WIDTH-1:0]  read1_value,
  input  logic [ADDR_W-1:0] read2_id,
  output logic [WIDTH-1:0]  read2_value,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_id,
  input  logic [WIDTH-1:0]  write_value,
  input  logic              pc_inc,
  input  logic [1:0]        sp_op,
  output logic [WIDTH-1:0]  pc_value,
  output logic [WIDTH-1:0]  sp_value,
  output logic              sp_fault
);

  localparam logic [ADDR_W:0]   NUM_REGS_W = NUM_REGS[ADDR_W:0];
  localparam logic [ADDR_W-1:0] SP_IDX     = SP_ID[ADDR_W-1:0];
  localparam logic [WIDTH-1:0]  ALL_ONES   = '1;
  localparam logic [WIDTH-1:0]  ONE        = WIDTH'(1);

  if (PC_ID == SP_ID || PC_ID >= NUM_REGS || SP_ID >= NUM_REGS ||
      NUM_REGS < 2 || NUM_REGS > (2 ** ADDR_W)) begin : g_bad_cfg
    $error("register_file_ctl: illegal PC_ID/SP_ID/NUM_REGS/ADDR_W combination");
  end

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  logic [NUM_REGS-1:0][WIDTH-1:0] regs_nxt;
  logic                           fault_nxt;
  logic                           write_in_range;

  assign write_in_range = write_en && ({1'b0, write_id} < NUM_REGS_W);

  // Adjusts first, explicit write last so a write to PC/SP always wins.
  always_comb begin
    regs_nxt  = regs;
    fault_nxt = sp_fault;
    if (pc_inc) begin
      regs_nxt[PC_ID] = regs[PC_ID] + ONE;
    end
    case (sp_op)
      2'b01: begin
        if (regs[SP_ID] == '0) fault_nxt = 1'b1;
        else                   regs_nxt[SP_ID] = regs[SP_ID] - ONE;
      end
      2'b10: begin
        if (regs[SP_ID] == ALL_ONES) fault_nxt = 1'b1;
        else                         regs_nxt[SP_ID] = regs[SP_ID] + ONE;
      end
      default: ;
    endcase
    for (int i = 0; i < NUM_REGS; i++) begin
      if (write_en && write_id == ADDR_W'(i)) begin
        regs_nxt[i] = write_value;
      end
    end
    if (write_en && write_id == SP_IDX) begin
      fault_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      regs[PC_ID] <= PC_RESET;
      regs[SP_ID] <= SP_RESET;
      sp_fault    <= 1'b0;
    end else begin
      regs     <= regs_nxt;
      sp_fault <= fault_nxt;
    end
  end

  // Out-of-range ids read as zero; forwarding never applies to dropped writes.
  always_comb begin
    read1_value = '0;
    read2_value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (read1_id == ADDR_W'(i)) read1_value = regs[i];
      if (read2_id == ADDR_W'(i)) read2_value = regs[i];
    end
    if (BYPASS != 0 && write_in_range) begin
      if (write_id == read1_id) read1_value = write_value;
      if (write_id == read2_id) read2_value = write_value;
    end
  end

  assign pc_value = regs[PC_ID];
  assign sp_value = regs[SP_ID];

endmodule

// File: tb/tb_register_file_ctl.sv
// Directed bench for register_file_ctl: one bypassing and one non-bypassing instance
// share stimulus; expectations go through a scoreboard queue.
module tb_register_file_ctl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] read1_id, read2_id, write_id;
  logic       write_en, pc_inc;
  logic [7:0] write_value;
  logic [1:0] sp_op;

  logic [7:0] r1, r2, pc, sp;
  logic       flt;
  logic [7:0] r1n, r2n, pcn, spn;
  logic       fltn;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  register_file_ctl #(.BYPASS(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .read1_id(read1_id), .read1_value(r1),
    .read2_id(read2_id), .read2_value(r2),
    .write_en(write_en), .write_id(write_id), .write_value(write_value),
    .pc_inc(pc_inc), .sp_op(sp_op),
    .pc_value(pc), .sp_value(sp), .sp_fault(flt)
  );

  register_file_ctl #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset_n(reset_n),
    .read1_id(read1_id), .read1_value(r1n),
    .read2_id(read2_id), .read2_value(r2n),
    .write_en(write_en), .write_id(write_id), .write_value(write_value),
    .pc_inc(pc_inc), .sp_op(sp_op),
    .pc_value(pcn), .sp_value(spn), .sp_fault(fltn)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic expect_v(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_v(input logic [7:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    write_en = 1'b0;
    pc_inc   = 1'b0;
    sp_op    = 2'b00;
  endtask

  initial begin
    logic [7:0] e;
    reset_n = 1'b1; idle();
    write_id = '0; write_value = '0; read1_id = '0; read2_id = '0;

    // 1: async reset asserted mid-cycle, then read every id
    #3 reset_n = 1'b0;
    #1;
    expect_v("rst_pc", 8'h00);   check_v(pc);
    expect_v("rst_sp", 8'hFF);   check_v(sp);
    expect_v("rst_fault", 8'h0); check_v({7'b0, flt});
    tick();
    @(negedge clock) reset_n = 1'b1;
    #1;
    for (int id = 0; id < 16; id++) begin
      read1_id = 4'(id);
      read2_id = 4'(15 - id);
      #1;
      expect_v($sformatf("rst_rd1_%0d", id), (id == 10) ? 8'hFF : 8'h00);
      expect_v($sformatf("rst_rd2_%0d", 15 - id), (15 - id == 10) ? 8'hFF : 8'h00);
      check_v(r1);
      check_v(r2);
    end

    // 2: write with bypass vs. no bypass, then an out-of-range write
    tick();
    read1_id = 4'd3; read2_id = 4'd3;
    write_en = 1'b1; write_id = 4'd3; write_value = 8'hA5;
    #1;
    expect_v("byp_rd1", 8'hA5);   check_v(r1);
    expect_v("byp_rd2", 8'hA5);   check_v(r2);
    expect_v("nobyp_rd1", 8'h00); check_v(r1n);
    expect_v("nobyp_rd2", 8'h00); check_v(r2n);
    expect_v("byp_after", 8'hA5);
    expect_v("nobyp_after", 8'hA5);
    tick(); idle();
    check_v(r1);
    check_v(r1n);

    write_en = 1'b1; write_id = 4'd14; write_value = 8'h77; read1_id = 4'd14;
    #1;
    expect_v("oor_byp", 8'h00); check_v(r1);
    tick(); idle();
    expect_v("oor_read", 8'h00); check_v(r1);
    for (int id = 0; id < 13; id++) begin
      read1_id = 4'(id);
      #1;
      e = (id == 3) ? 8'hA5 : (id == 10) ? 8'hFF : 8'h00;
      expect_v($sformatf("oor_keep_%0d", id), e);
      expect_v($sformatf("oor_keep_nb_%0d", id), e);
      check_v(r1);
      check_v(r1n);
    end

    // 3: PC increment with wrap, then write beats increment
    write_en = 1'b1; write_id = 4'd12; write_value = 8'hFE;
    tick(); idle();
    expect_v("pc_load", 8'hFE); check_v(pc);
    pc_inc = 1'b1; read1_id = 4'd12;
    #1;
    expect_v("pc_inc_no_fwd", 8'hFE); check_v(r1);
    for (int k = 1; k <= 3; k++) begin
      e = 8'hFE + 8'(k);
      expect_v($sformatf("pc_inc_%0d", k), e);
      expect_v($sformatf("pc_inc_nb_%0d", k), e);
      tick();
      check_v(pc);
      check_v(pcn);
    end
    write_en = 1'b1; write_id = 4'd12; write_value = 8'h40;
    tick(); idle();
    expect_v("pc_write_wins", 8'h40); check_v(pc);
    expect_v("pc_read", 8'h40);       check_v(r1);

    // 4: stack overflow / underflow
    sp_op = 2'b10;
    tick(); idle();
    expect_v("pop_ovf_sp", 8'hFF); check_v(sp);
    expect_v("pop_ovf_f", 8'h1);   check_v({7'b0, flt});
    sp_op = 2'b01;
    tick(); idle();
    expect_v("push_sp", 8'hFE);  check_v(sp);
    expect_v("push_f", 8'h1);    check_v({7'b0, flt});
    write_en = 1'b1; write_id = 4'd10; write_value = 8'h01;
    tick(); idle();
    expect_v("spw_sp", 8'h01); check_v(sp);
    expect_v("spw_f", 8'h0);   check_v({7'b0, flt});
    sp_op = 2'b01;
    tick();
    expect_v("push0_sp", 8'h00); check_v(sp);
    expect_v("push0_f", 8'h0);   check_v({7'b0, flt});
    tick(); idle();
    expect_v("unf_sp", 8'h00); check_v(sp);
    expect_v("unf_f", 8'h1);   check_v({7'b0, flt});
    expect_v("unf_f_nb", 8'h1); check_v({7'b0, fltn});

    // 5: simultaneous SP events
    write_en = 1'b1; write_id = 4'd10; write_value = 8'h10; sp_op = 2'b01;
    tick(); idle();
    expect_v("spw_push_sp", 8'h10); check_v(sp);
    expect_v("spw_push_f", 8'h0);   check_v({7'b0, flt});
    sp_op = 2'b10; pc_inc = 1'b1;
    write_en = 1'b1; write_id = 4'd0; write_value = 8'h5A; read1_id = 4'd0;
    tick(); idle();
    expect_v("multi_sp", 8'h11);   check_v(sp);
    expect_v("multi_pc", 8'h41);   check_v(pc);
    expect_v("multi_r0", 8'h5A);   check_v(r1);
    expect_v("multi_sp_nb", 8'h11); check_v(spn);
    expect_v("multi_pc_nb", 8'h41); check_v(pcn);

    // 6: async reset during pending write + adjust
    write_en = 1'b1; write_id = 4'd10; write_value = 8'hFF;
    tick(); idle();
    sp_op = 2'b10;
    tick(); idle();
    expect_v("pre_rst_f", 8'h1); check_v({7'b0, flt});
    write_en = 1'b1; write_id = 4'd5; write_value = 8'h33;
    pc_inc = 1'b1; sp_op = 2'b01;
    read1_id = 4'd0; read2_id = 4'd12;
    #2 reset_n = 1'b0;
    #1;
    expect_v("arst_pc", 8'h00);  check_v(pc);
    expect_v("arst_sp", 8'hFF);  check_v(sp);
    expect_v("arst_f", 8'h0);    check_v({7'b0, flt});
    expect_v("arst_r0", 8'h00);  check_v(r1);
    expect_v("arst_rpc", 8'h00); check_v(r2);
    tick(); idle();
    @(negedge clock) reset_n = 1'b1;
    read1_id = 4'd5;
    #1;
    expect_v("arst_r5_lost", 8'h00); check_v(r1);
    expect_v("arst_pc_hold", 8'h00); check_v(pc);
    tick();
    expect_v("arst_sp_hold", 8'hFF); check_v(sp);

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
